dot_mac_seq: RTL and testbench
==============================

Name: dot_mac_seq

Overview:
- Sequencing front-end for the 8x8 sequential multiplier (start/busy/product interface).
- Accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake.
- Issues one multiply per pair and accumulates the 16-bit products into an accumulator.
- After LEN pairs, presents the dot product on an output valid/ready handshake.
- Sits directly upstream of the multiplier, which it drives, and downstream of the multiplier's product output, which it consumes.

Parameters:
LEN, 4, pairs per dot product; legal 1..16.
ACC_W, 20, accumulator/result width; legal 16..32; sum wraps modulo 2^ACC_W.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  synchronous, active-low reset.
in_valid_i  in  1  operand pair valid.
in_ready_o  out  1  block can accept a pair.
a_bi  in  8  operand A, unsigned.
b_bi  in  8  operand B, unsigned.
sum_valid_o  out  1  dot product valid.
sum_ready_i  in  1  consumer accepts result.
sum_bo  out  ACC_W  dot product.
busy_o  out  1  high in any state other than IDLE, or when cnt != 0.
mul_start_o  out  1  one-cycle start pulse to multiplier.
mul_a_bo  out  8  registered operand A to multiplier.
mul_b_bo  out  8  registered operand B to multiplier.
mul_busy_i  in  1  multiplier busy.
mul_y_bi  in  16  multiplier product; valid once mul_busy_i falls.

Behaviour:
- Reset (rst_i=0 at edge), values:
  - state=IDLE; cnt=0; acc=0.
  - mul_a_bo=0, mul_b_bo=0.
  - Outputs: in_ready_o=1, sum_valid_o=0, sum_bo=0, mul_start_o=0, busy_o=0.
  - Reset mid-operation aborts immediately; the partial sum is discarded.
  - Multiplier state is not this block's concern.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, OUT.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i=1: latch a_bi/b_bi into mul_a_bo/mul_b_bo; go to ISSUE.
- ISSUE:
  - mul_start_o=1 (decoded from state, exactly one cycle); go to WAIT_HI.
- WAIT_HI:
  - Stay until mul_busy_i=1, then go to WAIT_LO.
  - No timeout: if busy never rises, the block waits until reset.
- WAIT_LO:
  - Stay while mul_busy_i=1.
  - On the first cycle mul_busy_i=0: acc <= acc + zero-extended mul_y_bi (mod 2^ACC_W).
  - If cnt==LEN-1: cnt<=0; go to OUT. Else: cnt<=cnt+1; go to IDLE.
- OUT:
  - sum_valid_o=1; sum_bo=acc (registered, stable while valid).
  - On sum_ready_i=1: acc<=0, sum_valid_o<=0; go to IDLE.
  - No new pair is accepted while in OUT.
- Handshake rules:
  - in_ready_o=0 in every state except IDLE.
  - in_valid_i outside IDLE is ignored; the data is not consumed.
  - sum_valid_o, once high, stays high with sum_bo stable until sum_ready_i=1.
- Operands mul_a_bo/mul_b_bo are held constant from the IDLE accept until the next accept.
- Latency per pair, with an M-cycle multiplier busy window:
  - accept -> ISSUE: 1 cycle; ISSUE -> busy seen: 1 cycle; M cycles busy; 1 accumulate cycle.
  - For M=8: 11 cycles from accept edge to return to IDLE.
- Width rules:
  - No saturation.
  - LEN*65025 exceeds 2^ACC_W only if the integrator chooses a small ACC_W; wrap is the defined behaviour.
- sum_ready_i asserted outside OUT has no effect.

Test Plan:
- Bench multiplier model: busy rises 1 cycle after start, stays high 8 cycles, and y=a*b is registered at the busy fall.
- LEN=4, ACC_W=20; pairs (1,1),(2,3),(255,255),(0,7), sum_ready_i=1 -> sum_bo=65032 (0xFE08), sum_valid_o high 1 cycle; exactly 4 mul_start_o pulses, each 1 cycle wide.
- LEN=2, ACC_W=16; pairs (255,255),(255,255) -> sum_bo=0xFC02 (130050 mod 65536).
- Backpressure: hold sum_ready_i=0 for 20 cycles after result, with in_valid_i=1 continuously:
  - sum_valid_o stays 1 and sum_bo is stable; in_ready_o=0.
  - On release, the next vector starts from acc=0.
- in_valid_i pulsed during WAIT_LO with (9,9) -> ignored; the final sum excludes 81, and in_ready_o was 0 that cycle.
- Reset mid-vector: rst_i=0 for 1 cycle during the third pair's WAIT_LO -> all outputs at reset values next cycle; a subsequent clean vector of (3,4)x4 gives 48.

Source files
------------

// File: rtl/dot_mac_seq.sv
// Dot-product sequencer: feeds operand pairs to an external 8x8 sequential
// multiplier one at a time and accumulates the products into a wrapping sum.
module dot_mac_seq #(
    parameter int LEN   = 4,
    parameter int ACC_W = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       a_bi,
    input  logic [7:0]       b_bi,
    output logic             sum_valid_o,
    input  logic             sum_ready_i,
    output logic [ACC_W-1:0] sum_bo,
    output logic             busy_o,
    output logic             mul_start_o,
    output logic [7:0]       mul_a_bo,
    output logic [7:0]       mul_b_bo,
    input  logic             mul_busy_i,
    input  logic [15:0]      mul_y_bi
);

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;

    // Modular accumulate: the product is zero-extended and the carry out of ACC_W is dropped.
    function automatic logic [ACC_W-1:0] acc_wrap_add(input logic [ACC_W-1:0] s,
                                                       input logic [15:0]      p);
        return s + ACC_W'(p);
    endfunction

    assign sum_bo = acc;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            mul_a_bo    <= '0;
            mul_b_bo    <= '0;
            in_ready_o  <= 1'b1;
            sum_valid_o <= 1'b0;
            mul_start_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            mul_start_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        mul_a_bo    <= a_bi;
                        mul_b_bo    <= b_bi;
                        state       <= ISSUE;
                        mul_start_o <= 1'b1;
                        in_ready_o  <= 1'b0;
                        busy_o      <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (mul_busy_i) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    // The product is only trusted on the first cycle after busy falls.
                    if (!mul_busy_i) begin
                        acc <= acc_wrap_add(acc, mul_y_bi);
                        if (cnt == LAST) begin
                            cnt         <= '0;
                            state       <= OUT;
                            sum_valid_o <= 1'b1;
                        end else begin
                            cnt        <= cnt + 5'd1;
                            state      <= IDLE;
                            in_ready_o <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (sum_ready_i) begin
                        acc         <= '0;
                        sum_valid_o <= 1'b0;
                        state       <= IDLE;
                        in_ready_o  <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    in_ready_o  <= 1'b1;
                    sum_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_mac_seq.sv
// Bench for dot_mac_seq: two instances (LEN=4/ACC_W=20 and LEN=2/ACC_W=16),
// each driving its own behavioural 8-cycle sequential multiplier.
module tb_dot_mac_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i = 1'b0;
    int   tests = 0;
    int   fails = 0;

    // instance 0: LEN=4, ACC_W=20
    logic        iv4 = 1'b0, sr4 = 1'b0;
    logic [7:0]  a4 = '0, b4 = '0;
    logic        ir4, sv4, bz4, st4;
    logic [19:0] s4;
    logic [7:0]  mopa4, mopb4;
    logic        mbusy4 = 1'b0;
    logic [15:0] my4 = '0;
    logic [2:0]  mcnt4 = '0;
    int          starts4 = 0, wide4 = 0;
    logic        st4_prev = 1'b0;

    // instance 1: LEN=2, ACC_W=16
    logic        iv2 = 1'b0, sr2 = 1'b0;
    logic [7:0]  a2 = '0, b2 = '0;
    logic        ir2, sv2, bz2, st2;
    logic [15:0] s2;
    logic [7:0]  mopa2, mopb2;
    logic        mbusy2 = 1'b0;
    logic [15:0] my2 = '0;
    logic [2:0]  mcnt2 = '0;

    dot_mac_seq #(.LEN(4), .ACC_W(20)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(iv4), .in_ready_o(ir4),
        .a_bi(a4), .b_bi(b4), .sum_valid_o(sv4), .sum_ready_i(sr4), .sum_bo(s4),
        .busy_o(bz4), .mul_start_o(st4), .mul_a_bo(mopa4), .mul_b_bo(mopb4),
        .mul_busy_i(mbusy4), .mul_y_bi(my4));

    dot_mac_seq #(.LEN(2), .ACC_W(16)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(iv2), .in_ready_o(ir2),
        .a_bi(a2), .b_bi(b2), .sum_valid_o(sv2), .sum_ready_i(sr2), .sum_bo(s2),
        .busy_o(bz2), .mul_start_o(st2), .mul_a_bo(mopa2), .mul_b_bo(mopb2),
        .mul_busy_i(mbusy2), .mul_y_bi(my2));

    // Multiplier models: busy rises the cycle after start, holds 8 cycles, product lands at the fall.
    always @(posedge clk) begin
        if (st4) begin
            mbusy4 <= 1'b1;
            mcnt4  <= 3'd7;
        end else if (mbusy4) begin
            if (mcnt4 == 3'd0) begin
                mbusy4 <= 1'b0;
                my4    <= 16'(mopa4) * 16'(mopb4);
            end else begin
                mcnt4 <= mcnt4 - 3'd1;
            end
        end
        if (st4) starts4++;
        if (st4 && st4_prev) wide4++;
        st4_prev <= st4;
    end

    always @(posedge clk) begin
        if (st2) begin
            mbusy2 <= 1'b1;
            mcnt2  <= 3'd7;
        end else if (mbusy2) begin
            if (mcnt2 == 3'd0) begin
                mbusy2 <= 1'b0;
                my2    <= 16'(mopa2) * 16'(mopb2);
            end else begin
                mcnt2 <= mcnt2 - 3'd1;
            end
        end
    end

    task automatic send_pair(input bit sel, input logic [7:0] a, input logic [7:0] b);
        int g = 0;
        while (!(sel ? ir2 : ir4) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            tests++;
            fails++;
            $display("FAIL send_pair: in_ready_o=0 after %0d cycles, required 1", g);
        end
        if (sel) begin iv2 = 1'b1; a2 = a; b2 = b; end
        else     begin iv4 = 1'b1; a4 = a; b4 = b; end
        @(negedge clk);
        iv2 = 1'b0;
        iv4 = 1'b0;
    endtask

    task automatic get_sum(input bit sel, input logic [31:0] exp, input string nm);
        int g = 0;
        logic [31:0] got;
        while (!(sel ? sv2 : sv4) && g < 300) begin
            @(negedge clk);
            g++;
        end
        got = sel ? 32'(s2) : 32'(s4);
        tests++;
        if (g >= 300) begin
            fails++;
            $display("FAIL %s: sum_valid_o never rose, required a result of %0d", nm, exp);
        end else if (got !== exp) begin
            fails++;
            $display("FAIL %s: sum_bo=%0d required %0d", nm, got, exp);
        end
        if (sel) sr2 = 1'b1; else sr4 = 1'b1;
        @(negedge clk);
        sr2 = 1'b0;
        sr4 = 1'b0;
        tests++;
        if ((sel ? sv2 : sv4) !== 1'b0) begin
            fails++;
            $display("FAIL %s_valid_drop: sum_valid_o=%b required 0", nm, sel ? sv2 : sv4);
        end
    endtask

    task automatic run_rand(input bit sel, input int n, input string nm);
        int unsigned s = 0;
        logic [7:0] a, b;
        sr4 = 1'($urandom_range(0, 1));
        sr2 = sr4;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            s += 32'(a) * 32'(b);
            send_pair(sel, a, b);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        if (!sr4) repeat ($urandom_range(0, 4)) @(negedge clk);
        get_sum(sel, sel ? (s % 32'h1_0000) : (s % 32'h10_0000), nm);
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (ir4 !== 1'b1) begin fails++; $display("FAIL rst_in_ready: %b required 1", ir4); end
        tests++; if (sv4 !== 1'b0) begin fails++; $display("FAIL rst_sum_valid: %b required 0", sv4); end
        tests++; if (s4 !== 20'd0) begin fails++; $display("FAIL rst_sum: %0d required 0", s4); end
        tests++; if (st4 !== 1'b0) begin fails++; $display("FAIL rst_start: %b required 0", st4); end
        tests++; if (bz4 !== 1'b0) begin fails++; $display("FAIL rst_busy: %b required 0", bz4); end
        tests++;
        if (mopa4 !== 8'd0 || mopb4 !== 8'd0) begin
            fails++;
            $display("FAIL rst_operands: a=%0d b=%0d required 0 0", mopa4, mopb4);
        end
        rst_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int cyc = 0;
        int st0 = starts4;
        sr4 = 1'b1;
        iv4 = 1'b1; a4 = 8'd1; b4 = 8'd1;
        @(negedge clk);
        iv4 = 1'b0;
        cyc = 1;
        while (!ir4 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (cyc != 11) begin fails++; $display("FAIL pair_latency: %0d cycles required 11", cyc); end
        send_pair(1'b0, 8'd2, 8'd3);
        send_pair(1'b0, 8'd255, 8'd255);
        send_pair(1'b0, 8'd0, 8'd7);
        sr4 = 1'b1;
        tests++;
        if (mopa4 !== 8'd0 || mopb4 !== 8'd7) begin
            fails++;
            $display("FAIL operands: a=%0d b=%0d required 0 7", mopa4, mopb4);
        end
        get_sum(1'b0, 32'd65032, "dot4");
        tests++;
        if (starts4 - st0 != 4) begin fails++; $display("FAIL start_count: %0d required 4", starts4 - st0); end
        tests++;
        if (wide4 != 0) begin fails++; $display("FAIL start_width: %0d wide pulses required 0", wide4); end
        tests++;
        if (mopa4 !== 8'd0 || mopb4 !== 8'd7) begin
            fails++;
            $display("FAIL operands_held: a=%0d b=%0d required 0 7", mopa4, mopb4);
        end
    endtask

    task automatic test_wrap();
        send_pair(1'b1, 8'd255, 8'd255);
        send_pair(1'b1, 8'd255, 8'd255);
        get_sum(1'b1, 32'h0000_FC02, "wrap16");
        for (int k = 0; k < 3; k++) run_rand(1'b1, 2, "rand16");
    endtask

    task automatic test_backpressure();
        int unsigned s = 0;
        int g = 0;
        int st0;
        bit bad_v = 0, bad_s = 0, bad_r = 0;
        logic [7:0] a, b;
        sr4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            s += 32'(a) * 32'(b);
            send_pair(1'b0, a, b);
        end
        while (!sv4 && g < 300) begin
            @(negedge clk);
            g++;
        end
        st0 = starts4;
        iv4 = 1'b1; a4 = 8'd200; b4 = 8'd100;
        for (int i = 0; i < 20; i++) begin
            if (sv4 !== 1'b1) bad_v = 1;
            if (32'(s4) !== s % 32'h10_0000) bad_s = 1;
            if (ir4 !== 1'b0) bad_r = 1;
            @(negedge clk);
        end
        tests++; if (bad_v) begin fails++; $display("FAIL bp_valid: sum_valid_o dropped, required 1"); end
        tests++; if (bad_s) begin fails++; $display("FAIL bp_sum: sum_bo=%0d required %0d", s4, s % 32'h10_0000); end
        tests++; if (bad_r) begin fails++; $display("FAIL bp_ready: in_ready_o went 1, required 0"); end
        tests++; if (starts4 != st0) begin fails++; $display("FAIL bp_start: %0d starts required 0", starts4 - st0); end
        iv4 = 1'b0;
        sr4 = 1'b1;
        @(negedge clk);
        sr4 = 1'b0;
        tests++;
        if (sv4 !== 1'b0 || ir4 !== 1'b1 || bz4 !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: valid=%b ready=%b busy=%b required 0 1 0", sv4, ir4, bz4);
        end
        run_rand(1'b0, 4, "after_bp");
    endtask

    task automatic test_ignore_wait_lo();
        int st0 = starts4;
        send_pair(1'b0, 8'd10, 8'd10);
        send_pair(1'b0, 8'd20, 8'd3);
        repeat (4) @(negedge clk);
        tests++;
        if (ir4 !== 1'b0 || mbusy4 !== 1'b1) begin
            fails++;
            $display("FAIL ign_ready: in_ready_o=%b mul_busy=%b required 0 1", ir4, mbusy4);
        end
        iv4 = 1'b1; a4 = 8'd9; b4 = 8'd9;
        @(negedge clk);
        iv4 = 1'b0;
        send_pair(1'b0, 8'd5, 8'd6);
        send_pair(1'b0, 8'd1, 8'd2);
        get_sum(1'b0, 32'd192, "ignore_wlo");
        tests++;
        if (starts4 - st0 != 4) begin fails++; $display("FAIL ign_starts: %0d required 4", starts4 - st0); end
    endtask

    task automatic test_reset_mid();
        send_pair(1'b0, 8'd50, 8'd50);
        send_pair(1'b0, 8'd60, 8'd60);
        send_pair(1'b0, 8'd70, 8'd70);
        repeat (4) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        tests++;
        if (ir4 !== 1'b1 || sv4 !== 1'b0 || s4 !== 20'd0 || st4 !== 1'b0 || bz4 !== 1'b0 ||
            mopa4 !== 8'd0 || mopb4 !== 8'd0) begin
            fails++;
            $display("FAIL mid_reset: rdy=%b vld=%b sum=%0d start=%b busy=%b a=%0d b=%0d required 1 0 0 0 0 0 0",
                     ir4, sv4, s4, st4, bz4, mopa4, mopb4);
        end
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) send_pair(1'b0, 8'd3, 8'd4);
        get_sum(1'b0, 32'd48, "after_reset");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_wrap();
        test_backpressure();
        test_ignore_wait_lo();
        test_reset_mid();
        for (int k = 0; k < 4; k++) run_rand(1'b0, 4, "rand20");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
